// File: rtl/scroll_scheduler_if.sv
// Bus bundle between the button/frame front end and the scroll scheduler.
// The master drives the one-cycle request pulses and the frame strobe.
// The slave (the scheduler) returns the offset and its status.
interface scroll_scheduler_if #(
  parameter int OFFSET_W = 4
);
  logic                step_pulse;
  logic                mode_pulse;
  logic                pause_pulse;
  logic                frame_sync;
  logic [OFFSET_W-1:0] offset;
  logic                offset_update;
  logic [1:0]          state;
  logic                pending;

  modport master (
    output step_pulse, mode_pulse, pause_pulse, frame_sync,
    input  offset, offset_update, state, pending
  );

  modport slave (
    input  step_pulse, mode_pulse, pause_pulse, frame_sync,
    output offset, offset_update, state, pending
  );
endinterface

// File: rtl/scroll_scheduler.sv
// Scroll scheduler: produces the message-memory offset for the character decoder.
// There are three modes: MANUAL (button stepping), AUTO_RUN (timed stepping) and
// AUTO_PAUSE (timer frozen, button single-steps).
// An offset change only lands on a frame_sync edge, so one refresh frame never
// mixes two offsets. A request that misses the frame edge is held as a single
// pending step.
// Optional macro SCROLL_BOUNCE_EN: when defined, the offset ping-pongs between
// 0 and MSG_LEN-1 instead of wrapping.
module scroll_scheduler #(
  parameter int TICK_DIV = 2500000,
  parameter int MSG_LEN  = 16,
  parameter int OFFSET_W = 4
) (
  input  logic                clk,
  input  logic                reset,  // synchronous, active-low
  scroll_scheduler_if.slave   bus
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0]   TICK_MAX = TICK_W'(TICK_DIV - 1);
  localparam logic [OFFSET_W-1:0] OFF_LAST = OFFSET_W'(MSG_LEN - 1);

  typedef enum logic [1:0] {
    ST_MANUAL     = 2'b00,
    ST_AUTO_RUN   = 2'b01,
    ST_AUTO_PAUSE = 2'b10
  } state_t;

  state_t              r_state;
  logic [TICK_W-1:0]   r_tick;
  logic [OFFSET_W-1:0] r_offset;
  logic                r_update;
  logic                r_pending;

  logic                w_req;      // a step is requested this cycle
  logic                w_discard;  // leaving auto mode drops any queued step
  logic [OFFSET_W-1:0] w_offset_adv;

`ifdef SCROLL_BOUNCE_EN
  logic r_dir_down;
  logic w_dir_adv;

  // Next offset and direction for one step in ping-pong mode
  always_comb begin
    w_offset_adv = r_offset;
    w_dir_adv    = r_dir_down;
    if (!r_dir_down) begin
      if (r_offset == OFF_LAST) begin
        w_offset_adv = OFFSET_W'(MSG_LEN - 2);
        w_dir_adv    = 1'b1;
      end else begin
        w_offset_adv = r_offset + 1'b1;
      end
    end else begin
      if (r_offset == '0) begin
        w_offset_adv = OFFSET_W'(1);
        w_dir_adv    = 1'b0;
      end else begin
        w_offset_adv = r_offset - 1'b1;
      end
    end
  end

  // Direction only changes when a step is actually applied
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_dir_down <= 1'b0;
    end else if (!w_discard && bus.frame_sync && (w_req || r_pending)) begin
      r_dir_down <= w_dir_adv;
    end
  end
`else
  // Next offset for one step in wrapping mode
  always_comb begin
    w_offset_adv = (r_offset == OFF_LAST) ? '0 : r_offset + 1'b1;
  end
`endif

  // Decode which event wins this cycle (mode > pause > step/tick)
  always_comb begin
    w_req     = 1'b0;
    w_discard = 1'b0;
    unique case (r_state)
      ST_MANUAL: begin
        // pause has no meaning here, so a step alongside it still counts
        w_req = !bus.mode_pulse && bus.step_pulse;
      end
      ST_AUTO_RUN: begin
        w_discard = bus.mode_pulse;
        w_req     = !bus.mode_pulse && !bus.pause_pulse && (r_tick == TICK_MAX);
      end
      ST_AUTO_PAUSE: begin
        w_discard = bus.mode_pulse;
        w_req     = !bus.mode_pulse && !bus.pause_pulse && bus.step_pulse;
      end
      default: begin
        w_req     = 1'b0;
        w_discard = 1'b0;
      end
    endcase
  end

  // Mode FSM, tick timer, pending queue and frame-aligned offset update
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_MANUAL;
      r_tick    <= '0;
      r_offset  <= '0;
      r_update  <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      unique case (r_state)
        ST_MANUAL: begin
          if (bus.mode_pulse) begin
            r_state <= ST_AUTO_RUN;
            r_tick  <= '0;
          end
        end
        ST_AUTO_RUN: begin
          if (bus.mode_pulse) begin
            r_state <= ST_MANUAL;
            r_tick  <= '0;
          end else if (bus.pause_pulse) begin
            r_state <= ST_AUTO_PAUSE;  // tick freezes at its current value
          end else if (r_tick == TICK_MAX) begin
            r_tick <= '0;
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
        ST_AUTO_PAUSE: begin
          if (bus.mode_pulse) begin
            r_state <= ST_MANUAL;
            r_tick  <= '0;
          end else if (bus.pause_pulse) begin
            r_state <= ST_AUTO_RUN;    // resumes from the held tick
          end
        end
        default: begin
          r_state <= ST_MANUAL;
          r_tick  <= '0;
        end
      endcase

      r_update <= 1'b0;
      if (w_discard) begin
        r_pending <= 1'b0;
      end else if (bus.frame_sync) begin
        if (w_req || r_pending) begin
          r_offset <= w_offset_adv;
          r_update <= 1'b1;
        end
        r_pending <= 1'b0;
      end else if (w_req) begin
        // a second request while one is queued is simply absorbed
        r_pending <= 1'b1;
      end
    end
  end

  assign bus.offset        = r_offset;
  assign bus.offset_update = r_update;
  assign bus.state         = r_state;
  assign bus.pending       = r_pending;

endmodule

// File: tb/tb_scroll_scheduler.sv
// Bench for scroll_scheduler: directed scenarios plus random pulses, every
// cycle compared against an abstract model of the scheduling rules.
module tb_scroll_scheduler;
  localparam int TD = 4;
  localparam int ML = 6;
  localparam int OW = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  scroll_scheduler_if #(.OFFSET_W(OW)) bus ();

  scroll_scheduler #(.TICK_DIV(TD), .MSG_LEN(ML), .OFFSET_W(OW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: state 0 manual, 1 running, 2 paused
  int m_off = 0, m_tick = 0, m_state = 0;
  bit m_pend = 0, m_upd = 0, m_down = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_advance();
`ifdef SCROLL_BOUNCE_EN
    if (!m_down) begin
      if (m_off == ML - 1) begin m_down = 1; m_off = ML - 2; end
      else m_off = m_off + 1;
    end else begin
      if (m_off == 0) begin m_down = 0; m_off = 1; end
      else m_off = m_off - 1;
    end
`else
    m_off = (m_off + 1) % ML;
`endif
  endfunction

  function automatic void model_step(bit rst_n, bit st, bit md, bit ps, bit fs);
    bit req, drop;
    if (!rst_n) begin
      m_off = 0; m_tick = 0; m_state = 0; m_pend = 0; m_upd = 0; m_down = 0;
      return;
    end
    req = 0; drop = 0;
    if (md) begin
      drop = (m_state != 0);
      m_state = (m_state == 0) ? 1 : 0;
      m_tick = 0;
    end else if (m_state == 0) begin
      req = st;
    end else if (ps) begin
      m_state = (m_state == 1) ? 2 : 1;
    end else if (m_state == 1) begin
      m_tick = m_tick + 1;
      if (m_tick == TD) begin m_tick = 0; req = 1; end
    end else begin
      req = st;
    end
    m_upd = 0;
    if (drop) m_pend = 0;
    else if (fs) begin
      if (req || m_pend) begin model_advance(); m_upd = 1; end
      m_pend = 0;
    end else if (req) m_pend = 1;
  endfunction

  task automatic cycle(input bit st, input bit md, input bit ps, input bit fs);
    bus.step_pulse  = st;
    bus.mode_pulse  = md;
    bus.pause_pulse = ps;
    bus.frame_sync  = fs;
    @(posedge clk);
    model_step(reset, st, md, ps, fs);
    #1;
    check("offset",  32'(bus.offset),        32'(m_off));
    check("update",  32'(bus.offset_update), 32'(m_upd));
    check("state",   32'(bus.state),         32'(m_state));
    check("pending", 32'(bus.pending),       32'(m_pend));
    $display("cyc st=%0b md=%0b ps=%0b fs=%0b rst=%0b -> off=%0d upd=%0b state=%0d pend=%0b",
             st, md, ps, fs, reset, bus.offset, bus.offset_update, bus.state, bus.pending);
  endtask

  initial begin
    bit found;
    bus.step_pulse = 0; bus.mode_pulse = 0; bus.pause_pulse = 0; bus.frame_sync = 1;

    // Reset
    reset = 0;
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    check("rst_offset", 32'(bus.offset), 0);
    check("rst_state", 32'(bus.state), 0);
    reset = 1;

    // Three manual steps, spaced 3 cycles apart
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0, 1);
      cycle(0, 0, 0, 1);
      cycle(0, 0, 0, 1);
    end
    check("manual_3", 32'(bus.offset), 3);

    // Auto scroll for 30 cycles
    cycle(0, 1, 0, 1);
    for (int i = 0; i < 30; i++) cycle(0, 0, 0, 1);
    check("auto_state", 32'(bus.state), 1);

    // Pause at tick 2, single step, resume
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (m_tick == 2) found = 1;
      else cycle(0, 0, 0, 1);
    end
    check("tick_sync", 32'(found), 1);
    cycle(0, 0, 1, 1);
    check("paused", 32'(bus.state), 2);
    cycle(1, 0, 0, 1);
    check("pause_step_upd", 32'(bus.offset_update), 1);
    cycle(0, 0, 1, 1);
    check("resumed", 32'(bus.state), 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1);

    // All three pulses together in AUTO_RUN: mode wins
    cycle(1, 1, 1, 1);
    check("coinc_state", 32'(bus.state), 0);
    check("coinc_upd", 32'(bus.offset_update), 0);

    // Sparse frame_sync in MANUAL, two steps per frame
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 10; k++) begin
        cycle(k == 2 || k == 5, 0, 0, k == 9);
        if (k == 2) check("pend_set", 32'(bus.pending), 1);
      end
    end

    // Reach offset 4 in MANUAL, queue a step, then reset over it
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (m_off == 4) found = 1;
      else cycle(1, 0, 0, 1);
    end
    check("reach_4", 32'(found), 1);
    cycle(1, 0, 0, 0);
    check("pend_before_rst", 32'(bus.pending), 1);
    reset = 0;
    cycle(0, 0, 0, 0);
    reset = 1;
    check("rst_mid_off", 32'(bus.offset), 0);
    check("rst_mid_pend", 32'(bus.pending), 0);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    check("rst_no_upd", 32'(bus.offset_update), 0);

    // Random pulses against the model
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) != 0);
      cycle($urandom_range(0, 5) == 0, $urandom_range(0, 29) == 0,
            $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
    end
    reset = 1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
